// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word type, NOP encoding, fetch state encoding.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port, at most one request outstanding.
interface fetch_stage_if;

    logic                imem_req;
    mips_pkg::word_t     imem_addr;
    logic                imem_ready;
    logic                imem_rvalid;
    mips_pkg::word_t     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: branch beats jump, otherwise sequential PC+4.
module pc_next_sel
    import mips_pkg::*;
(
    input  word_t i_pc_plus4,
    input  logic  i_pcsrc,
    input  word_t i_branch_target,
    input  logic  i_jump,
    input  word_t i_jump_target,
    output word_t o_pc_next_c,
    output logic  o_redirect_c
);

    // Priority select of the next fetch address
    always_comb begin
        o_pc_next_c = i_pc_plus4;
        if (i_pcsrc) begin
            o_pc_next_c = i_branch_target;
        end else if (i_jump) begin
            o_pc_next_c = i_jump_target;
        end
    end

    assign o_redirect_c = i_pcsrc | i_jump;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, single-outstanding imem port,
// stall hold buffer and decode redirects. Optional feature macro:
// FETCH_MISALIGN_CHECK_EN (align redirect targets and flag misaligned ones).
module fetch_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          EN_F,
    input  logic          PCSrc_D,
    input  word_t         PCBranch_D,
    input  logic          Jump_D,
    input  word_t         PCJump_D,
    fetch_stage_if.master imem,
    output word_t         inst_R_F,
    output word_t         PCPlus4_F,
    output logic          fetch_valid,
    output logic          fetch_misalign
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    word_t        r_pc;
    word_t        w_pc_nxt;
    word_t        r_hold;
    word_t        w_hold_nxt;
    logic         r_kill;
    logic         w_kill_nxt;

    word_t        w_pc_plus4;
    word_t        w_pc_sel;
    word_t        w_target;
    logic         w_redirect;
    logic         w_live;
    logic         w_req;
    logic         w_accept;
    word_t        w_addr;
    logic         w_valid;
    word_t        w_inst;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next_sel u_pc_next_sel (
        .i_pc_plus4      (w_pc_plus4),
        .i_pcsrc         (PCSrc_D),
        .i_branch_target (PCBranch_D),
        .i_jump          (Jump_D),
        .i_jump_target   (PCJump_D),
        .o_pc_next_c     (w_pc_sel),
        .o_redirect_c    (w_redirect)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_target = {w_pc_sel[31:2], 2'b00};

    // Sticky flag for any redirect whose target is not word-aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_redirect && (w_pc_sel[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign fetch_misalign = r_misalign;
`else
    assign w_target       = w_pc_sel;
    assign fetch_misalign = 1'b0;
`endif

    // A response that belongs to the current PC and is not squashed this cycle
    assign w_live   = imem.imem_rvalid && !r_kill && !w_redirect;
    assign w_accept = w_req && imem.imem_ready;

    // State register: PC, fetch state, kill flag, hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_hold  <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state: advance, hold, squash and redirect decisions
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_hold_nxt  = r_hold;
        if (w_redirect) begin
            w_pc_nxt = w_target;
            case (r_state)
                // An accepted request must still drain, so it is tracked as killed in WAIT
                FS_REQ: begin
                    w_state_nxt = w_accept ? FS_WAIT : FS_REQ;
                    w_kill_nxt  = w_accept;
                end
                FS_WAIT: begin
                    if (imem.imem_rvalid) begin
                        w_state_nxt = FS_REQ;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = FS_WAIT;
                        w_kill_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = FS_REQ;
                    w_kill_nxt  = 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                FS_REQ: begin
                    if (w_accept) begin
                        w_state_nxt = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (r_kill) begin
                            w_state_nxt = FS_REQ;
                            w_kill_nxt  = 1'b0;
                        end else if (EN_F) begin
                            w_pc_nxt    = w_target;
                            w_state_nxt = w_accept ? FS_WAIT : FS_REQ;
                        end else begin
                            w_hold_nxt  = imem.imem_rdata;
                            w_state_nxt = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (EN_F) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = FS_REQ;
                    end
                end
                default: begin
                    w_state_nxt = FS_REQ;
                end
            endcase
        end
    end

    // Outputs: request port and presented instruction (NOP bubble by default)
    always_comb begin
        w_req   = 1'b0;
        w_addr  = r_pc;
        w_valid = 1'b0;
        w_inst  = NOP_INST;
        if (!rst) begin
            case (r_state)
                FS_REQ: begin
                    w_req = 1'b1;
                end
                FS_WAIT: begin
                    if (w_live && EN_F) begin
                        w_valid = 1'b1;
                        w_inst  = imem.imem_rdata;
                        w_req   = 1'b1;
                        w_addr  = w_pc_plus4;
                    end
                end
                FS_HOLD: begin
                    if (!w_redirect) begin
                        w_valid = 1'b1;
                        w_inst  = r_hold;
                    end
                end
                default: begin
                    w_req = 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;
    assign inst_R_F       = w_inst;
    assign fetch_valid    = w_valid;
    assign PCPlus4_F      = w_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: variable-latency memory model, expected
// instruction stream queue restarted on reset/redirect, negedge monitor.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam word_t RST_PC = 32'h0000_0000;

    logic  clk   = 1'b0;
    logic  rst   = 1'b1;
    logic  en_f  = 1'b1;
    logic  pcsrc = 1'b0;
    logic  jump  = 1'b0;
    word_t br_t  = '0;
    word_t j_t   = '0;
    word_t inst_f;
    word_t pcp4_f;
    logic  fvalid;
    logic  fmis;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .EN_F           (en_f),
        .PCSrc_D        (pcsrc),
        .PCBranch_D     (br_t),
        .Jump_D         (jump),
        .PCJump_D       (j_t),
        .imem           (imem_bus),
        .inst_R_F       (inst_f),
        .PCPlus4_F      (pcp4_f),
        .fetch_valid    (fvalid),
        .fetch_misalign (fmis)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // memory model controls (written by the driver only)
    int   mem_lat     = 1;
    int   ready_pct   = 100;
    logic ready_block = 1'b0;
    logic keep_on_rst = 1'b0;
    int   phase       = 0;

    // memory model state
    logic  m_pend   = 1'b0;
    int    m_cnt    = 0;
    word_t m_addr   = '0;
    logic  acc_s    = 1'b0;
    word_t acc_addr = '0;

    function automatic word_t mem_word(input word_t a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // handshake sampled away from the clock edge
    always @(negedge clk) begin
        acc_s    = imem_bus.imem_req && imem_bus.imem_ready;
        acc_addr = imem_bus.imem_addr;
    end

    // memory: random ready, response mem_lat cycles after accept
    always @(posedge clk) begin
        imem_bus.imem_rvalid <= 1'b0;
        imem_bus.imem_ready  <= !ready_block && (int'($urandom_range(99)) < ready_pct);
        if (rst && !keep_on_rst) begin
            m_pend <= 1'b0;
        end else begin
            if (m_pend) begin
                if (m_cnt <= 1) begin
                    imem_bus.imem_rvalid <= 1'b1;
                    imem_bus.imem_rdata  <= mem_word(m_addr);
                    m_pend               <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (acc_s) begin
                if (mem_lat <= 1) begin
                    imem_bus.imem_rvalid <= 1'b1;
                    imem_bus.imem_rdata  <= mem_word(acc_addr);
                end else begin
                    m_pend <= 1'b1;
                    m_addr <= acc_addr;
                    m_cnt  <= mem_lat - 1;
                end
            end
        end
    end

    // scoreboard state (monitor only)
    word_t exp_q[$];
    word_t exp_req   = '0;
    logic  req_armed = 1'b0;
    logic  exp_mis   = 1'b0;
    int    idle      = 0;
    int    rst_cyc   = 0;
    int    zw_cyc    = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void restart(input word_t base);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    endfunction

    // monitor: reference stream is "instruction at PC, PC+4, ..." from the last restart
    always @(negedge clk) begin : mon
        word_t raw;
        if (rst) begin
            if (rst_cyc > 0) begin
                check("rst_req",      32'(imem_bus.imem_req), 32'd0);
                check("rst_valid",    32'(fvalid), 32'd0);
                check("rst_inst",     inst_f, NOP_INST);
                check("rst_pcplus4",  pcp4_f, RST_PC + 32'd4);
                check("rst_misalign", 32'(fmis), 32'd0);
            end
            rst_cyc++;
            restart(RST_PC);
            exp_req   = RST_PC;
            req_armed = 1'b1;
            exp_mis   = 1'b0;
            idle      = 0;
            zw_cyc    = 0;
        end else begin
            rst_cyc = 0;
            check("misalign", 32'(fmis), 32'(exp_mis));
            if (imem_bus.imem_req && imem_bus.imem_ready)
                check("one_outstanding", 32'(m_pend), 32'd0);
            if (phase == 1) begin
                if (zw_cyc == 0) check("zw_first_bubble", 32'(fvalid), 32'd0);
                else             check("zw_streak",       32'(fvalid), 32'd1);
                zw_cyc++;
            end
            if (pcsrc || jump) begin
                raw = pcsrc ? br_t : j_t;
                check("redir_bubble", 32'(fvalid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
                if (raw[1:0] != 2'b00) exp_mis = 1'b1;
                raw = raw & 32'hFFFF_FFFC;
`endif
                restart(raw);
                exp_req   = raw;
                req_armed = 1'b1;
                idle      = 0;
            end else begin
                if (req_armed && imem_bus.imem_req) begin
                    check("first_req_addr", imem_bus.imem_addr, exp_req);
                    req_armed = 1'b0;
                end
                if (fvalid) begin
                    check("inst",    inst_f, mem_word(exp_q[0]));
                    check("pcplus4", pcp4_f, exp_q[0] + 32'd4);
                    if (en_f) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() < 2) exp_q.push_back(exp_q[$] + 32'd4);
                    end else begin
                        check("hold_no_req", 32'(imem_bus.imem_req), 32'd0);
                    end
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > 80) begin
                        n_total++;
                        $display("FAIL progress_timeout: %0d cycles without a valid instruction, limit 80", idle);
                        idle = 0;
                    end
                end
            end
        end
    end

    task automatic wait_accept();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (imem_bus.imem_req && imem_bus.imem_ready) return;
        end
        $display("FAIL wait_accept: no request accepted within 50 cycles");
        $fatal(1, "bench stopped on handshake timeout");
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver
    initial begin
        word_t tmp;
        rst = 1'b1;
        cycles(3);
        rst   = 1'b0;
        phase = 1;
        cycles(18);
        phase = 0;

        // stall 3 cycles while a response arrives
        en_f = 1'b0;
        cycles(3);
        en_f = 1'b1;
        cycles(6);

        // branch while waiting on a 3-cycle response
        mem_lat = 3;
        wait_accept();
        cycles(1);
        pcsrc = 1'b1;
        br_t  = 32'h0000_0100;
        cycles(1);
        pcsrc = 1'b0;
        cycles(12);

        // branch and jump together: branch wins
        mem_lat = 1;
        pcsrc = 1'b1; br_t = 32'h0000_0040;
        jump  = 1'b1; j_t  = 32'h0000_0080;
        cycles(1);
        pcsrc = 1'b0;
        jump  = 1'b0;
        cycles(10);

        // reset while in WAIT; late response must be ignored
        mem_lat = 4;
        wait_accept();
        cycles(1);
        keep_on_rst = 1'b1;
        ready_block = 1'b1;
        rst         = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(5);
        ready_block = 1'b0;
        cycles(2);
        keep_on_rst = 1'b0;
        mem_lat     = 1;
        cycles(8);

`ifdef FETCH_MISALIGN_CHECK_EN
        // misaligned jump target
        jump = 1'b1;
        j_t  = 32'h0000_0102;
        cycles(1);
        jump = 1'b0;
        cycles(10);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(6);
`endif

        // randomized traffic
        ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            en_f    = (int'($urandom_range(99)) < 80);
            mem_lat = int'($urandom_range(4, 1));
            if (int'($urandom_range(99)) < 5) begin
                pcsrc = 1'($urandom_range(1));
                jump  = 1'($urandom_range(1));
                if (!pcsrc && !jump) jump = 1'b1;
                tmp  = $urandom;
                br_t = tmp & 32'h0000_0FFC;
                tmp  = $urandom;
                j_t  = tmp & 32'h0000_0FFC;
            end else begin
                pcsrc = 1'b0;
                jump  = 1'b0;
            end
            cycles(1);
        end
        pcsrc     = 1'b0;
        jump      = 1'b0;
        en_f      = 1'b1;
        ready_pct = 100;
        cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
